// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons on one saturating 2-stage datapath.
// Optional per-neuron refractory counters are enabled with `define LIF_REFRACTORY_EN.
module lif_neuron_array #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int W = 16,
  parameter int FRAC = 8,
  parameter logic signed [W-1:0] THRESHOLD = 16'sh3200,
  parameter logic signed [W-1:0] V_RESET = 16'sh0000,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic signed [W-1:0] in_current,
  input  logic signed [W-1:0] dt_tau,
  input  logic                clear_req,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_idx,
  output logic signed [W-1:0] out_v,
  output logic                out_spike
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  if (REFRAC_CYCLES < 1 || REFRAC_CYCLES > 255) begin : g_bad_refrac
    $error("REFRAC_CYCLES must be in 1..255");
  end

  function automatic logic signed [2*W-1:0] sext(input logic signed [W-1:0] x);
    return {{W{x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [2*W-1:0] x);
    if (x > MAXV) return MAXV[W-1:0];
    else if (x < MINV) return MINV[W-1:0];
    else return x[W-1:0];
  endfunction

  state_t             state, state_n;
  logic [IDX_W-1:0]   cnt;
  logic               cnt_last, clr_we, fire;

  logic               s1_vld, s2_vld;
  logic [IDX_W-1:0]   s1_idx, s2_idx;
  logic signed [W-1:0] s1_i, s2_v, s2_diff;
  logic signed [W-1:0] v_rd, diff, delta, v_new, res_v, wb_v;
  logic signed [2*W-1:0] prod;
  logic               fwd, spike_n, res_spk;

  logic signed [W-1:0] mem_v [N_NEURONS];

`ifdef LIF_REFRACTORY_EN
  localparam logic [7:0] REFRAC = 8'(REFRAC_CYCLES);
  logic [7:0] mem_r [N_NEURONS];
  logic [7:0] r_rd, s2_r, wb_r;
`endif

  assign fire     = in_valid && in_ready;
  assign cnt_last = (cnt == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_n;
  end

  // Leave RUN straight for CLEAR when nothing will still be in flight after this edge.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (clear_req) state_n = (fire || s1_vld) ? DRAIN : CLEAR;
      DRAIN:   if (!s1_vld) state_n = CLEAR;
      CLEAR:   if (cnt_last) state_n = RUN;
      default: state_n = CLEAR;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    clr_we   = (state == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clr_we) cnt <= cnt_last ? '0 : cnt + 1'b1;
  end

  // S1: read with forwarding from the S2 write-back in the same cycle.
  always_comb begin
    fwd  = s2_vld && (s2_idx == s1_idx);
    v_rd = fwd ? wb_v : mem_v[s1_idx];
    diff = sat(sext(s1_i) - sext(v_rd));
`ifdef LIF_REFRACTORY_EN
    r_rd = fwd ? wb_r : mem_r[s1_idx];
`endif
  end

  // S2: leak/integrate, threshold, and the value to store back.
  always_comb begin
    prod    = sext(s2_diff) * sext(dt_tau);
    delta   = sat(prod >>> FRAC);
    v_new   = sat(sext(s2_v) + sext(delta));
    spike_n = (v_new >= THRESHOLD);
    res_v   = v_new;
    res_spk = spike_n;
    wb_v    = spike_n ? V_RESET : v_new;
`ifdef LIF_REFRACTORY_EN
    wb_r = spike_n ? REFRAC : 8'd0;
    if (s2_r != 8'd0) begin
      res_v   = V_RESET;
      res_spk = 1'b0;
      wb_v    = V_RESET;
      wb_r    = s2_r - 8'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_i    <= '0;
      s2_idx  <= '0;
      s2_v    <= '0;
      s2_diff <= '0;
`ifdef LIF_REFRACTORY_EN
      s2_r    <= '0;
`endif
    end else begin
      s1_vld <= fire;
      s2_vld <= s1_vld;
      if (fire) begin
        s1_idx <= in_idx;
        s1_i   <= in_current;
      end
      if (s1_vld) begin
        s2_idx  <= s1_idx;
        s2_v    <= v_rd;
        s2_diff <= diff;
`ifdef LIF_REFRACTORY_EN
        s2_r    <= r_rd;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_v     <= '0;
      out_spike <= 1'b0;
    end else begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_idx   <= s2_idx;
        out_v     <= res_v;
        out_spike <= res_spk;
      end
    end
  end

  // State is initialised only by the clear sweep; S2 is always idle while it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_v[cnt] <= V_RESET;
`ifdef LIF_REFRACTORY_EN
      mem_r[cnt] <= 8'd0;
`endif
    end else if (s2_vld) begin
      mem_v[s2_idx] <= wb_v;
`ifdef LIF_REFRACTORY_EN
      mem_r[s2_idx] <= wb_r;
`endif
    end
  end

endmodule
